// File: rtl/halut_pkg.sv
// halut_pkg: shared HALUT decoder constants, accumulation mode enum, result vector type and FP helpers.
// Latency: n/a (combinational helper functions only).
// Backpressure: n/a.
package halut_pkg;

  typedef enum logic {
    FP32 = 1'b0,
    INT  = 1'b1
  } accumulation_enum_t;

  localparam int unsigned K             = 16;
  localparam int unsigned C             = 32;
  localparam int unsigned M             = 4;
  localparam int unsigned DataTypeWidth = 16;
  localparam accumulation_enum_t AccumulationOption = INT;

  // every accumulator lane and result column is 32 bits wide
  localparam int unsigned AccWidth = 32;

  typedef logic [M-1:0][AccWidth-1:0] result_vec_t;

  // Exact FP16 -> FP32 widening; FP16 subnormals become FP32 normals.
  function automatic logic [31:0] fp16_to_fp32(input logic [15:0] h);
    logic [31:0] f;
    logic [9:0]  m;
    logic [7:0]  e;
    f = {h[15], 31'b0};
    m = h[9:0];
    e = 8'd112;
    if (h[14:10] == 5'h1F) begin
      f = {h[15], 8'hFF, h[9:0], 13'b0};
    end else if (h[14:10] != 5'h00) begin
      f = {h[15], 8'(h[14:10]) + 8'd112, h[9:0], 13'b0};
    end else if (h[9:0] != 10'h000) begin
      // bring the leading one to bit 9, it then becomes the hidden bit
      for (int i = 0; i < 10; i++) begin
        if (!m[9]) begin
          m = m << 1;
          e = e - 8'd1;
        end
      end
      f = {h[15], e, m[8:0], 14'b0};
    end
    return f;
  endfunction

  // FP32 add, round-to-nearest-even; subnormal operands and results flush to zero.
  function automatic logic [31:0] fp32_add(input logic [31:0] a, input logic [31:0] b);
    logic [31:0] x, y, res;
    logic [7:0]  d;
    logic [26:0] mx, my, ext, mask;
    logic [27:0] s;
    logic [24:0] rm;
    logic signed [9:0] e;
    logic az, bz;
    az   = (a[30:23] == 8'h00);
    bz   = (b[30:23] == 8'h00);
    res  = 32'h0;
    x    = a;
    y    = b;
    my   = 27'd0;
    mask = 27'd0;
    if (a[30:23] == 8'hFF || b[30:23] == 8'hFF) begin
      if ((a[30:23] == 8'hFF && a[22:0] != 23'd0) || (b[30:23] == 8'hFF && b[22:0] != 23'd0))
        res = 32'h7FC00000;
      else if (a[30:23] == 8'hFF && b[30:23] == 8'hFF && a[31] != b[31])
        res = 32'h7FC00000;
      else if (a[30:23] == 8'hFF)
        res = a;
      else
        res = b;
    end else if (az && bz) begin
      res = {a[31] & b[31], 31'b0};
    end else if (az) begin
      res = b;
    end else if (bz) begin
      res = a;
    end else begin
      // order by magnitude so the difference is never negative
      if (a[30:0] < b[30:0]) begin
        x = b;
        y = a;
      end
      d   = x[30:23] - y[30:23];
      mx  = {1'b1, x[22:0], 3'b000};
      ext = {1'b1, y[22:0], 3'b000};
      if (d > 8'd26) begin
        my = 27'd1;
      end else begin
        mask = (27'd1 << d) - 27'd1;
        my   = (ext >> d) | {26'b0, |(ext & mask)};
      end
      e = $signed({2'b00, x[30:23]});
      if (x[31] ^ y[31]) s = {1'b0, mx} - {1'b0, my};
      else               s = {1'b0, mx} + {1'b0, my};
      if (s[27]) begin
        s = {1'b0, s[27:2], s[1] | s[0]};
        e = e + 10'sd1;
      end
      for (int i = 0; i < 27; i++) begin
        if (!s[26] && s != 28'd0) begin
          s = s << 1;
          e = e - 10'sd1;
        end
      end
      rm = {1'b0, s[26:3]} + 25'(s[2] && (s[1] || s[0] || s[3]));
      if (rm[24]) begin
        rm = rm >> 1;
        e  = e + 10'sd1;
      end
      if (s == 28'd0)        res = 32'h0;
      else if (e <= 10'sd0)  res = {x[31], 31'b0};
      else if (e >= 10'sd255) res = {x[31], 8'hFF, 23'b0};
      else                   res = {x[31], e[7:0], rm[22:0]};
    end
    return res;
  endfunction

endpackage

// File: rtl/halut_acc_lane.sv
// halut_acc_lane: one output column -- stage-2 adder, running accumulator and result register.
// Latency: a stage-1 word is folded into the accumulator (or result) on the next advancing edge.
// Backpressure: holds all state while advance_i is low. Define HALUT_DECODER_SAT_EN for INT saturation.
module halut_acc_lane #(
  parameter int unsigned DataTypeWidth = halut_pkg::DataTypeWidth,
  parameter halut_pkg::accumulation_enum_t AccumulationOption = halut_pkg::AccumulationOption
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     clear_i,
  input  logic                     advance_i,
  input  logic                     s1_vld_i,
  input  logic                     s1_last_i,
  input  logic [DataTypeWidth-1:0] word_i,
  output logic [31:0]              result_o
);
  import halut_pkg::*;

  logic [AccWidth-1:0] acc_q;
  logic [AccWidth-1:0] res_q;
  logic [AccWidth-1:0] sum_d;

  generate
    if (AccumulationOption == FP32) begin : g_fp
      logic [15:0] w16;
      assign w16   = 16'(word_i);
      assign sum_d = fp32_add(acc_q, fp16_to_fp32(w16));
    end else begin : g_int
      logic [AccWidth-1:0] ext;
      assign ext = AccWidth'($signed(word_i));
`ifdef HALUT_DECODER_SAT_EN
      logic [AccWidth:0] wide;
      assign wide  = {acc_q[AccWidth-1], acc_q} + {ext[AccWidth-1], ext};
      assign sum_d = (wide[AccWidth] != wide[AccWidth-1])
                   ? (wide[AccWidth] ? {1'b1, {(AccWidth-1){1'b0}}} : {1'b0, {(AccWidth-1){1'b1}}})
                   : wide[AccWidth-1:0];
`else
      assign sum_d = acc_q + ext;
`endif
    end
  endgenerate

  // accumulate mid-row words; on the row's last word publish the sum and restart from zero
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      acc_q <= '0;
      res_q <= '0;
    end else if (clear_i) begin
      acc_q <= '0;
    end else if (advance_i && s1_vld_i) begin
      if (s1_last_i) begin
        res_q <= sum_d;
        acc_q <= '0;
      end else begin
        acc_q <= sum_d;
      end
    end
  end

  assign result_o = res_q;

endmodule

// File: rtl/halut_decoder_mx.sv
// halut_decoder_mx: sums C shared-LUT lookups per row into M 32-bit columns (FP32 or INT).
// Latency: last beat of a row accepted at edge t -> out_valid_o high after edge t+1.
// Backpressure: in_ready_o = !out_valid_o || out_ready_i; pipeline holds while a result waits.
// Optional: define HALUT_DECODER_SAT_EN to saturate INT accumulation instead of wrapping.
module halut_decoder_mx #(
  parameter int unsigned K             = halut_pkg::K,
  parameter int unsigned C             = halut_pkg::C,
  parameter int unsigned M             = halut_pkg::M,
  parameter int unsigned DataTypeWidth = halut_pkg::DataTypeWidth,
  parameter halut_pkg::accumulation_enum_t AccumulationOption = halut_pkg::AccumulationOption,
  parameter int unsigned CAddrWidth    = $clog2(C),
  parameter int unsigned TreeDepth     = $clog2(K),
  parameter int unsigned MAddrWidth    = (M > 1) ? $clog2(M) : 1,
  parameter int unsigned LUTAddrWidth  = CAddrWidth + TreeDepth + MAddrWidth
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     we_i,
  input  logic [LUTAddrWidth-1:0]  waddr_i,
  input  logic [DataTypeWidth-1:0] wdata_i,
  input  logic                     in_valid_i,
  output logic                     in_ready_o,
  input  logic [CAddrWidth-1:0]    c_addr_i,
  input  logic [TreeDepth-1:0]     k_addr_i,
  input  logic                     clear_i,
  output logic                     out_valid_o,
  input  logic                     out_ready_i,
  output logic [M*32-1:0]          result_o,
  output logic                     err_o
);
  import halut_pkg::*;

  logic [DataTypeWidth-1:0]          lut_q [2**LUTAddrWidth];
  logic [M-1:0][DataTypeWidth-1:0]   rd_words;

  logic [CAddrWidth-1:0]             cnt_q, cnt_d;
  logic                              last_beat;
  logic                              s1_vld_q, s1_last_q;
  logic [M-1:0][DataTypeWidth-1:0]   s1_words_q;
  logic                              out_valid_q, err_q;
  logic                              advance, accept;
  logic [M-1:0][AccWidth-1:0]        lane_res;

  assign advance   = !out_valid_q || out_ready_i;
  assign accept    = in_valid_i && advance && !clear_i;
  assign last_beat = (cnt_q == CAddrWidth'(C - 1));
  assign cnt_d     = last_beat ? '0 : cnt_q + 1'b1;

  // shared LUT storage; a same-cycle read of the written address still sees the old word
  always_ff @(posedge clk_i) begin
    if (we_i) lut_q[waddr_i] <= wdata_i;
  end

  // fetch all M column words of the presented (c,k) entry
  always_comb begin
    rd_words = '0;
    for (int mi = 0; mi < M; mi++) begin
      rd_words[mi] = lut_q[{c_addr_i, k_addr_i, MAddrWidth'(mi)}];
    end
  end

  // beat counter and sticky sequence check; a mismatched beat is still consumed
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else if (clear_i) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else if (accept) begin
      cnt_q <= cnt_d;
      if (c_addr_i != cnt_q) err_q <= 1'b1;
    end
  end

  // stage 1: capture the looked-up words and the row-end flag
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      s1_vld_q   <= 1'b0;
      s1_last_q  <= 1'b0;
      s1_words_q <= '0;
    end else if (clear_i) begin
      s1_vld_q   <= 1'b0;
    end else if (advance) begin
      s1_vld_q <= accept;
      if (accept) begin
        s1_words_q <= rd_words;
        s1_last_q  <= last_beat;
      end
    end
  end

  // output valid: set by a new final sum, dropped by a handshake without one
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      out_valid_q <= 1'b0;
    end else if (clear_i) begin
      out_valid_q <= 1'b0;
    end else if (advance) begin
      out_valid_q <= s1_vld_q && s1_last_q;
    end
  end

  generate
    for (genvar gm = 0; gm < M; gm++) begin : g_lane
      halut_acc_lane #(
        .DataTypeWidth     (DataTypeWidth),
        .AccumulationOption(AccumulationOption)
      ) u_lane (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .clear_i  (clear_i),
        .advance_i(advance),
        .s1_vld_i (s1_vld_q),
        .s1_last_i(s1_last_q),
        .word_i   (s1_words_q[gm]),
        .result_o (lane_res[gm])
      );
    end
  endgenerate

  assign in_ready_o  = advance;
  assign out_valid_o = out_valid_q;
  assign result_o    = lane_res;
  assign err_o       = err_q;

endmodule

// File: tb/tb_halut_decoder_mx.sv
// tb_halut_decoder_mx: scoreboard bench for an INT instance (C=4, M=2, 32-bit entries) and an FP32 instance.
// Latency: expected results queued at stimulus time, popped by per-instance monitors on each handshake.
// Backpressure: exercised by holding out_ready low while a second row completes.
module tb_halut_decoder_mx;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // INT instance signals
  logic        i_we = 0;
  logic [6:0]  i_waddr = '0;
  logic [31:0] i_wdata = '0;
  logic        i_vld = 0, i_rdy, i_clr = 0, i_ovld, i_ordy = 1, i_err;
  logic [1:0]  i_c = '0;
  logic [3:0]  i_k = '0;
  logic [63:0] i_res;

  // FP32 instance signals
  logic         f_we = 0;
  logic [10:0]  f_waddr = '0;
  logic [15:0]  f_wdata = '0;
  logic         f_vld = 0, f_rdy, f_clr = 0, f_ovld, f_ordy = 1, f_err;
  logic [4:0]   f_c = '0;
  logic [3:0]   f_k = '0;
  logic [127:0] f_res;

  logic [63:0]  i_q[$];
  logic [127:0] f_q[$];
  logic [63:0]  exp_a, exp_b, exp_sat;
  logic [127:0] f_exp_one, f_exp_mix;
  bit           fed;

  halut_decoder_mx #(
    .K(16), .C(4), .M(2), .DataTypeWidth(32), .AccumulationOption(halut_pkg::INT)
  ) u_int (
    .clk_i(clk), .rst_ni(rst_n), .we_i(i_we), .waddr_i(i_waddr), .wdata_i(i_wdata),
    .in_valid_i(i_vld), .in_ready_o(i_rdy), .c_addr_i(i_c), .k_addr_i(i_k),
    .clear_i(i_clr), .out_valid_o(i_ovld), .out_ready_i(i_ordy), .result_o(i_res), .err_o(i_err)
  );

  halut_decoder_mx #(
    .K(16), .C(32), .M(4), .DataTypeWidth(16), .AccumulationOption(halut_pkg::FP32)
  ) u_fp (
    .clk_i(clk), .rst_ni(rst_n), .we_i(f_we), .waddr_i(f_waddr), .wdata_i(f_wdata),
    .in_valid_i(f_vld), .in_ready_o(f_rdy), .c_addr_i(f_c), .k_addr_i(f_k),
    .clear_i(f_clr), .out_valid_o(f_ovld), .out_ready_i(f_ordy), .result_o(f_res), .err_o(f_err)
  );

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, expv);
    end
  endtask

  // scoreboard monitors: one pop per output handshake
  always @(negedge clk) begin
    if (rst_n && i_ovld && i_ordy) begin
      if (i_q.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL int_unexpected_result: got %h, expected no result", i_res);
      end else begin
        chk("int_result", {64'b0, i_res}, {64'b0, i_q.pop_front()});
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && f_ovld && f_ordy) begin
      if (f_q.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL fp_unexpected_result: got %h, expected no result", f_res);
      end else begin
        chk("fp_result", f_res, f_q.pop_front());
      end
    end
  end

  task automatic i_write(input int c, input int k, input int m, input logic [31:0] d);
    i_we = 1; i_waddr = {2'(c), 4'(k), 1'(m)}; i_wdata = d;
    @(posedge clk); #1;
    i_we = 0;
  endtask

  task automatic f_write(input int c, input int k, input int m, input logic [15:0] d);
    f_we = 1; f_waddr = {5'(c), 4'(k), 2'(m)}; f_wdata = d;
    @(posedge clk); #1;
    f_we = 0;
  endtask

  // present one beat until an edge accepts it (ready sampled mid-cycle)
  task automatic i_beat(input int c, input int k);
    int  g;
    bit  ok;
    g = 0; ok = 0;
    i_vld = 1; i_c = 2'(c); i_k = 4'(k);
    while (!ok && g < 200) begin
      @(negedge clk); ok = i_rdy;
      @(posedge clk); g++;
    end
    #1; i_vld = 0;
    if (!ok) begin
      n_cmp++; n_bad++;
      $display("FAIL int_beat_timeout: got no ready in %0d cycles, expected ready", g);
    end
  endtask

  task automatic f_beat(input int c, input int k);
    int  g;
    bit  ok;
    g = 0; ok = 0;
    f_vld = 1; f_c = 5'(c); f_k = 4'(k);
    while (!ok && g < 200) begin
      @(negedge clk); ok = f_rdy;
      @(posedge clk); g++;
    end
    #1; f_vld = 0;
    if (!ok) begin
      n_cmp++; n_bad++;
      $display("FAIL fp_beat_timeout: got no ready in %0d cycles, expected ready", g);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end

  initial begin
    exp_a     = {32'hFFFFFFF8, 32'd4};
    exp_b     = {32'hFFFFFFFA, 32'd100};
`ifdef HALUT_DECODER_SAT_EN
    exp_sat   = {32'h80000000, 32'h7FFFFFFF};
`else
    exp_sat   = {32'h00000000, 32'hFFFFFFFC};
`endif
    f_exp_one = {4{32'h42000000}};
    f_exp_mix = {32'h36000000, 32'h41800000, 32'hC2000000, 32'h42000000};

    repeat (3) @(posedge clk);
    #1;
    chk("int_reset_ready", i_rdy, 1);
    chk("int_reset_valid", i_ovld, 0);
    chk("int_reset_result", i_res, 0);
    chk("int_reset_err", i_err, 0);
    chk("fp_reset_valid", f_ovld, 0);
    chk("fp_reset_result", f_res, 0);
    rst_n = 1;
    @(posedge clk); #1;

    // LUT: k=0 and k=7 give column0=1, column1=-2; k=5 row-specific values
    for (int c = 0; c < 4; c++) begin
      i_write(c, 0, 0, 32'd1);
      i_write(c, 0, 1, 32'hFFFFFFFE);
      i_write(c, 7, 0, 32'd1);
      i_write(c, 7, 1, 32'hFFFFFFFE);
      i_write(c, 5, 0, 32'(10 * (c + 1)));
      i_write(c, 5, 1, 32'(-c));
      i_write(c, 9, 0, 32'h7FFFFFFF);
      i_write(c, 9, 1, 32'h80000000);
    end

    // basic row and latency
    i_q.push_back(exp_a);
    for (int c = 0; c < 4; c++) i_beat(c, 0);
    chk("int_latency_not_early", i_ovld, 0);
    @(posedge clk); #1;
    chk("int_latency_valid", i_ovld, 1);
    @(posedge clk); #1;
    chk("int_single_pulse", i_ovld, 0);
    chk("int_err_clean", i_err, 0);

    // back-to-back rows, no gaps
    i_q.push_back(exp_a);
    i_q.push_back(exp_b);
    for (int c = 0; c < 4; c++) i_beat(c, 0);
    for (int c = 0; c < 4; c++) i_beat(c, 5);
    repeat (3) @(posedge clk);
    #1;

    // backpressure while the second row completes
    i_ordy = 0;
    fed = 0;
    i_q.push_back(exp_a);
    i_q.push_back(exp_b);
    fork
      begin
        for (int c = 0; c < 4; c++) i_beat(c, 0);
        for (int c = 0; c < 4; c++) i_beat(c, 5);
        fed = 1;
      end
    join_none
    repeat (10) @(posedge clk);
    #2;
    chk("int_bp_valid_held", i_ovld, 1);
    chk("int_bp_ready_low", i_rdy, 0);
    chk("int_bp_result_first", i_res, exp_a);
    repeat (2) @(posedge clk);
    #2;
    chk("int_bp_result_stable", i_res, exp_a);
    i_ordy = 1;
    for (int g = 0; g < 100 && !fed; g++) @(posedge clk);
    chk("int_bp_feed_done", fed, 1);
    repeat (3) @(posedge clk);
    #1;

    // sequence error, then clear with a simultaneous (dropped) beat
    i_beat(0, 0);
    i_beat(2, 0);
    chk("int_err_set", i_err, 1);
    repeat (3) @(posedge clk);
    #1;
    chk("int_err_sticky", i_err, 1);
    i_clr = 1; i_vld = 1; i_c = 2'd0; i_k = 4'd0;
    @(posedge clk); #1;
    i_clr = 0; i_vld = 0;
    chk("int_clear_err", i_err, 0);
    chk("int_clear_valid", i_ovld, 0);
    chk("int_clear_result_kept", i_res, exp_b);
    i_q.push_back(exp_a);
    for (int c = 0; c < 4; c++) i_beat(c, 0);
    repeat (3) @(posedge clk);
    #1;
    chk("int_err_after_clear", i_err, 0);

    // write in the same cycle as a read of that entry: old data used, new data next row
    i_q.push_back(exp_a);
    i_q.push_back({32'hFFFFFFF8, 32'd103});
    i_we = 1; i_waddr = {2'd0, 4'd7, 1'd0}; i_wdata = 32'd100;
    i_beat(0, 7);
    i_we = 0;
    for (int c = 1; c < 4; c++) i_beat(c, 7);
    for (int c = 0; c < 4; c++) i_beat(c, 7);
    repeat (3) @(posedge clk);
    #1;

    // extreme entries: saturate or wrap depending on build
    i_q.push_back(exp_sat);
    for (int c = 0; c < 4; c++) i_beat(c, 9);
    repeat (3) @(posedge clk);
    #1;

    // FP32 instance: k=0 all 1.0, k=3 columns {1.0, -1.0, 0.5, min subnormal}
    for (int c = 0; c < 32; c++) begin
      for (int m = 0; m < 4; m++) f_write(c, 0, m, 16'h3C00);
      f_write(c, 3, 0, 16'h3C00);
      f_write(c, 3, 1, 16'hBC00);
      f_write(c, 3, 2, 16'h3800);
      f_write(c, 3, 3, 16'h0001);
    end
    f_q.push_back(f_exp_one);
    for (int c = 0; c < 32; c++) f_beat(c, 0);
    f_q.push_back(f_exp_mix);
    for (int c = 0; c < 32; c++) f_beat(c, 3);
    repeat (3) @(posedge clk);
    #1;

    // reset mid-row
    for (int c = 0; c < 10; c++) f_beat(c, 0);
    rst_n = 0;
    #1;
    chk("rst_mid_fp_result", f_res, 0);
    chk("rst_mid_fp_valid", f_ovld, 0);
    chk("rst_mid_fp_ready", f_rdy, 1);
    chk("rst_mid_int_result", i_res, 0);
    #2;
    rst_n = 1;
    @(posedge clk); #1;
    f_q.push_back(f_exp_one);
    for (int c = 0; c < 32; c++) f_beat(c, 0);
    repeat (3) @(posedge clk);
    #1;
    chk("fp_err_after_reset", f_err, 0);

    chk("int_queue_drained", i_q.size(), 0);
    chk("fp_queue_drained", f_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
